// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - serializing UART transmitter: start, LSB-first data, optional parity, stop
module uart_tx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [5:0]            prescale,
    output logic                  TX_OUT,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [5:0]              edge_q, edge_d;
    logic [BW-1:0]           bit_q, bit_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    par_en_q, par_en_d;
    logic                    par_bit_q, par_bit_d;
    logic [5:0]              prescale_q, prescale_d;
    logic                    tx_q, tx_d;
    logic                    last_edge;

    // prescale 0 makes the compare value 63, giving a 64-cycle bit
    assign last_edge = (edge_q == (prescale_q - 6'd1));

    always_comb begin
        state_d    = state_q;
        edge_d     = edge_q;
        bit_d      = bit_q;
        data_d     = data_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        prescale_d = prescale_q;
        tx_d       = 1'b1;

        if (state_q == IDLE) begin
            if (DATA_VALID) begin
                state_d    = START;
                edge_d     = 6'd0;
                bit_d      = '0;
                data_d     = P_DATA;
                par_en_d   = PAR_EN;
                par_bit_d  = (^P_DATA) ^ PAR_TYP;
                prescale_d = prescale;
            end
        end else if (last_edge) begin
            edge_d = 6'd0;
            case (state_q)
                START:  state_d = DATA;
                DATA: begin
                    if (bit_q == LAST_BIT) begin
                        bit_d   = '0;
                        state_d = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
                PARITY: state_d = STOP;
                STOP:   state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end else begin
            edge_d = edge_q + 6'd1;
        end

        // Line level is registered from the next state so it flips exactly at bit boundaries
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = data_d[bit_d];
            PARITY:  tx_d = par_bit_d;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            edge_q     <= 6'd0;
            bit_q      <= '0;
            data_q     <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            prescale_q <= 6'd0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            edge_q     <= edge_d;
            bit_q      <= bit_d;
            data_q     <= data_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            prescale_q <= prescale_d;
            tx_q       <= tx_d;
        end
    end

    assign TX_OUT  = tx_q;
    assign busy    = (state_q != IDLE);
    assign tx_done = (state_q == STOP) && last_edge;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed self-checking bench for uart_tx (8-bit and 5-bit instances)
module tb_uart_tx;

    logic       clk;
    logic       rst;
    logic [7:0] pd8;
    logic [4:0] pd5;
    logic       dv8, dv5;
    logic       par_en, par_typ;
    logic [5:0] prescale;
    logic       tx8, busy8, done8;
    logic       tx5, busy5, done5;

    int vec   = 0;
    int fails = 0;

    uart_tx #(.DATA_WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .P_DATA(pd8), .DATA_VALID(dv8),
        .PAR_EN(par_en), .PAR_TYP(par_typ), .prescale(prescale),
        .TX_OUT(tx8), .busy(busy8), .tx_done(done8)
    );

    uart_tx #(.DATA_WIDTH(5)) dut5 (
        .clk(clk), .rst(rst), .P_DATA(pd5), .DATA_VALID(dv5),
        .PAR_EN(par_en), .PAR_TYP(par_typ), .prescale(prescale),
        .TX_OUT(tx5), .busy(busy5), .tx_done(done5)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Frame bits are listed LSB first: exp[0] is the start bit.
    task automatic check_frame(input bit sel, input logic [15:0] exp, input int nb,
                               input int p, input int flip_cyc, input string name);
        int  b;
        logic t, bz, d;
        for (int cyc = 0; cyc < nb * p; cyc++) begin
            b  = cyc / p;
            t  = sel ? tx5 : tx8;
            bz = sel ? busy5 : busy8;
            d  = sel ? done5 : done8;
            vec++;
            if (t !== exp[b]) begin
                fails++;
                $display("FAIL %s tx cyc=%0d got=%b exp=%b", name, cyc, t, exp[b]);
            end
            vec++;
            if (bz !== 1'b1) begin
                fails++;
                $display("FAIL %s busy cyc=%0d got=%b exp=1", name, cyc, bz);
            end
            vec++;
            if (d !== (cyc == nb * p - 1)) begin
                fails++;
                $display("FAIL %s tx_done cyc=%0d got=%b exp=%b", name, cyc, d, (cyc == nb * p - 1));
            end
            if (cyc == flip_cyc) pd8 = 8'hFF;
            @(negedge clk);
        end
        t  = sel ? tx5 : tx8;
        bz = sel ? busy5 : busy8;
        d  = sel ? done5 : done8;
        vec++;
        if ({t, bz, d} !== 3'b100) begin
            fails++;
            $display("FAIL %s idle_after got tx/busy/done=%b exp=100", name, {t, bz, d});
        end
    endtask

    task automatic send(input bit sel, input logic [7:0] data, input logic pe,
                        input logic pt, input logic [5:0] ps);
        @(negedge clk);
        par_en   = pe;
        par_typ  = pt;
        prescale = ps;
        if (sel) begin pd5 = data[4:0]; dv5 = 1'b1; end
        else     begin pd8 = data;      dv8 = 1'b1; end
        @(negedge clk);
        dv5 = 1'b0;
        dv8 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        dv8 = 1'b0;
        dv5 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        vec++;
        if ({tx8, busy8, done8} !== 3'b100) begin
            fails++;
            $display("FAIL reset_state got tx/busy/done=%b exp=100", {tx8, busy8, done8});
        end
        vec++;
        if ({tx5, busy5, done5} !== 3'b100) begin
            fails++;
            $display("FAIL reset_state5 got tx/busy/done=%b exp=100", {tx5, busy5, done5});
        end
    endtask

    task automatic test_parity();
        send(0, 8'hA5, 1'b1, 1'b0, 6'd8);
        check_frame(0, {5'b0, 1'b1, 1'b0, 8'hA5, 1'b0}, 11, 8, -1, "even_a5");
        send(0, 8'hA5, 1'b1, 1'b1, 6'd8);
        check_frame(0, {5'b0, 1'b1, 1'b1, 8'hA5, 1'b0}, 11, 8, -1, "odd_a5");
        send(0, 8'hA5, 1'b0, 1'b0, 6'd8);
        check_frame(0, {6'b0, 1'b1, 8'hA5, 1'b0}, 10, 8, -1, "nopar_a5");
        send(1, 8'h13, 1'b1, 1'b0, 6'd8);
        check_frame(1, {8'b0, 1'b1, 1'b1, 5'h13, 1'b0}, 8, 8, -1, "w5_even_13");
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        par_en   = 1'b0;
        par_typ  = 1'b0;
        prescale = 6'd4;
        pd8      = 8'h00;
        dv8      = 1'b1;
        @(negedge clk);
        check_frame(0, {6'b0, 1'b1, 8'h00, 1'b0}, 10, 4, 20, "b2b_first");
        @(negedge clk);
        dv8 = 1'b0;
        check_frame(0, {6'b0, 1'b1, 8'hFF, 1'b0}, 10, 4, -1, "b2b_second");
        @(negedge clk);
        vec++;
        if (busy8 !== 1'b0) begin
            fails++;
            $display("FAIL b2b_no_third busy got=%b exp=0", busy8);
        end
    endtask

    task automatic test_prescale_extremes();
        send(0, 8'h3C, 1'b0, 1'b0, 6'd1);
        check_frame(0, {6'b0, 1'b1, 8'h3C, 1'b0}, 10, 1, -1, "ps1_3c");
        send(0, 8'h81, 1'b0, 1'b0, 6'd0);
        check_frame(0, {6'b0, 1'b1, 8'h81, 1'b0}, 10, 64, -1, "ps0_81");
    endtask

    task automatic test_reset_mid_frame();
        send(0, 8'h5A, 1'b0, 1'b0, 6'd16);
        repeat (70) @(negedge clk);
        vec++;
        if (tx8 !== 1'b1 || busy8 !== 1'b1) begin
            fails++;
            $display("FAIL midrst_pre got tx/busy=%b%b exp=11", tx8, busy8);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vec++;
        if ({tx8, busy8, done8} !== 3'b100) begin
            fails++;
            $display("FAIL midrst_after got tx/busy/done=%b exp=100", {tx8, busy8, done8});
        end
        @(negedge clk);
        send(0, 8'hC3, 1'b1, 1'b1, 6'd16);
        check_frame(0, {5'b0, 1'b1, 1'b1, 8'hC3, 1'b0}, 11, 16, -1, "midrst_new");
    endtask

    task automatic test_rst_and_request();
        @(negedge clk);
        rst      = 1'b1;
        pd8      = 8'h55;
        prescale = 6'd2;
        dv8      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        dv8 = 1'b0;
        vec++;
        if ({tx8, busy8} !== 2'b10) begin
            fails++;
            $display("FAIL simul_rst got tx/busy=%b exp=10", {tx8, busy8});
        end
        @(negedge clk);
        vec++;
        if ({tx8, busy8} !== 2'b10) begin
            fails++;
            $display("FAIL simul_rst_later got tx/busy=%b exp=10", {tx8, busy8});
        end
    endtask

    initial begin
        rst      = 1'b1;
        pd8      = 8'h00;
        pd5      = 5'h00;
        dv8      = 1'b0;
        dv5      = 1'b0;
        par_en   = 1'b0;
        par_typ  = 1'b0;
        prescale = 6'd8;
        test_reset();
        test_parity();
        test_back_to_back();
        test_prescale_extremes();
        test_reset_mid_frame();
        test_rst_and_request();
        $display("== %0d vectors applied, %0d miscompares ==", vec, fails);
        $finish;
    end

endmodule
